vend_ctrl_param: RTL
====================

# vend_ctrl_param

Parametrised vending controller: the next generation of the fixed three-beverage, nickel/dime/quarter machine. It supports a configurable beverage count and price table, a balance ceiling with coin rejection, and greedy one-coin-per-cycle change dispensing with a busy indication. Optional per-beverage stock tracking is compiled in by macro. It sits between the coin/button front end and the dispenser/coin-return actuators.

## Interface
- NUM_BEV, 4, number of beverage channels (1–16)
- BAL_W, 9, balance width in cents
- MAX_BAL, 500, maximum balance in cents; must be < 2^BAL_W
- PRICES, {150,200,75,175}, packed NUM_BEV×BAL_W vector; slice i is the price of beverage i (bev0=175, bev1=75, bev2=200, bev3=150); each price a non-zero multiple of 5
- STOCK_INIT, 8, initial units per beverage (used only with stock feature)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_q, in_d, in_n  in  1 each  coin-accepted pulses: 25¢, 10¢, 5¢
- bev_sel  in  NUM_BEV  selection buttons, one bit per beverage
- cancel  in  1  return entire balance
- bev_out  out  NUM_BEV  one-cycle dispense pulse per beverage
- disp_q, disp_d, disp_n  out  1 each  one-cycle coin-return pulses
- coin_reject  out  1  one-cycle pulse: a coin in this cycle was not credited
- balance  out  BAL_W  current credit in cents
- busy  out  1  high while in CHANGE
- sold_out  out  NUM_BEV  bit i high when beverage i stock is 0

## Operation
- States: IDLE, CHANGE. All outputs registered.
- IDLE, per-cycle priority: cancel > bev_sel > coin.
  - cancel with balance>0 → CHANGE; with balance=0 → no effect.
  - bev_sel: lowest set index i wins. If balance ≥ PRICES[i] (and not sold out): bev_out[i] pulses, balance −= price, then CHANGE if the remainder is >0, else stay IDLE. Otherwise the selection is ignored with no state change.
  - Coin: at most one credited per cycle, priority q > d > n. Any other coin in the same cycle pulses coin_reject. A coin that would make balance > MAX_BAL is rejected (coin_reject, balance unchanged).
  - A coin arriving in the same cycle as an accepted cancel or selection is rejected.
- CHANGE, one coin per cycle, greedy:
  - balance ≥25 → disp_q, −25
  - else ≥10 → disp_d, −10
  - else disp_n, −5
  - Return to IDLE on the cycle balance reaches 0.
  - All coins, bev_sel and cancel are ignored; coins pulse coin_reject.
- Balance arithmetic: unsigned BAL_W. Underflow is impossible by construction (multiples of 5, compare before subtract).

## Timing
- Reset (async, any state including mid-CHANGE): state IDLE, balance 0, all pulses 0, busy 0, stock counters = STOCK_INIT, sold_out = 0 (or 1 where STOCK_INIT=0).
- Inputs are sampled on rising edge k; effects are visible after edge k:
  - balance update: 1-cycle latency
  - bev_out: 1-cycle latency
- First change coin appears in the cycle after the vend/cancel edge; busy rises in the same cycle.
- Change of C cents takes floor(C/25) + floor((C mod 25)/10) + ((C mod 25) mod 10)/5 cycles. busy falls with the last coin.
- Inputs are level-sampled each cycle. A held input is treated as repeated pulses, so the front end must deliver single-cycle pulses.

## Configuration
- VEND_STOCK_EN defined:
  - per-beverage counters, loaded with STOCK_INIT at reset
  - a successful vend decrements the counter
  - a selection with stock 0 is ignored
  - sold_out[i] = (stock_i == 0)
- Undefined: unlimited stock, sold_out tied to 0, no counters synthesised.

## Test plan
- 7×Q, D, N (190¢), bev_sel[0] → bev_out[0] pulse, balance 15, then disp_d, disp_n on consecutive cycles, busy high 2 cycles, balance 0.
- 3×Q, bev_sel[1] → bev_out[1] pulse, balance 0, no coin-return pulses, busy never high.
- Q, D, N (40¢), cancel → disp_q, disp_d, disp_n on consecutive cycles, balance 0. Second cancel at 0 → no outputs.
- 2×Q, bev_sel[2] → ignored, balance stays 50. Fill to 500, then Q → coin_reject, balance 500. in_q & in_n same cycle at 0 → balance 25, coin_reject. Coin during CHANGE → coin_reject, change sequence unchanged.
- 9×Q, D, N (240¢), bev_sel[2] → bev_out[2], balance 40. Assert rst_n low after the first disp_q → balance 0, busy 0, no further pulses.
- VEND_STOCK_EN, STOCK_INIT=1: two bev1 purchases with 75¢ each → first vends and sold_out[1] rises; second is ignored with balance 75. Without the macro, sold_out stays 0 and both vend.

Source files
------------

// File: rtl/vend_ctrl_param.sv
// Parametrised vending controller: coin credit, priced selection, greedy change return.
// Define VEND_STOCK_EN to compile in per-beverage stock counters and sold_out tracking.
module vend_ctrl_param #(
  parameter int NUM_BEV = 4,
  parameter int BAL_W = 9,
  parameter int MAX_BAL = 500,
  parameter logic [NUM_BEV*BAL_W-1:0] PRICES = {9'd150, 9'd200, 9'd75, 9'd175},
  parameter int STOCK_INIT = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_q,
  input  logic               in_d,
  input  logic               in_n,
  input  logic [NUM_BEV-1:0] bev_sel,
  input  logic               cancel,
  output logic [NUM_BEV-1:0] bev_out,
  output logic               disp_q,
  output logic               disp_d,
  output logic               disp_n,
  output logic               coin_reject,
  output logic [BAL_W-1:0]   balance,
  output logic               busy,
  output logic [NUM_BEV-1:0] sold_out
);

  typedef enum logic {IDLE, CHANGE} state_t;

  localparam logic [BAL_W:0]   MAX_X = (BAL_W+1)'(MAX_BAL);
  localparam logic [BAL_W-1:0] VAL_Q = BAL_W'(25);
  localparam logic [BAL_W-1:0] VAL_D = BAL_W'(10);
  localparam logic [BAL_W-1:0] VAL_N = BAL_W'(5);

  state_t             state, state_n;
  logic [BAL_W-1:0]   balance_n, sel_price, coin_val;
  logic [BAL_W:0]     coin_sum;
  logic [NUM_BEV-1:0] sel_oh, bev_out_n;
  logic               dq_n, dd_n, dn_n, rej_n, busy_n, any_coin, extra_coin;

  always_comb begin
    state_n    = state;
    balance_n  = balance;
    bev_out_n  = '0;
    dq_n       = 1'b0;
    dd_n       = 1'b0;
    dn_n       = 1'b0;
    rej_n      = 1'b0;
    sel_price  = '0;
    coin_val   = '0;
    coin_sum   = '0;
    any_coin   = in_q | in_d | in_n;
    extra_coin = (in_q & (in_d | in_n)) | (in_d & in_n);
    // Isolate the lowest set selection bit; only that beverage is considered.
    sel_oh     = bev_sel & (~bev_sel + NUM_BEV'(1));
    for (int i = 0; i < NUM_BEV; i++) begin
      if (sel_oh[i]) sel_price = sel_price | PRICES[i*BAL_W +: BAL_W];
    end

    case (state)
      IDLE: begin
        if (cancel && balance != '0) begin
          state_n = CHANGE;
          rej_n   = any_coin;
        end else if (sel_oh != '0 && (sel_oh & sold_out) == '0 && balance >= sel_price) begin
          bev_out_n = sel_oh;
          balance_n = balance - sel_price;
          rej_n     = any_coin;
          if (balance_n != '0) state_n = CHANGE;
        end else if (any_coin) begin
          coin_val = in_q ? VAL_Q : (in_d ? VAL_D : VAL_N);
          coin_sum = {1'b0, balance} + {1'b0, coin_val};
          if (coin_sum > MAX_X) begin
            rej_n = 1'b1;
          end else begin
            balance_n = coin_sum[BAL_W-1:0];
            rej_n     = extra_coin;
          end
        end
      end
      CHANGE: begin
        rej_n = any_coin;
        if (balance >= VAL_Q) begin
          dq_n      = 1'b1;
          balance_n = balance - VAL_Q;
        end else if (balance >= VAL_D) begin
          dd_n      = 1'b1;
          balance_n = balance - VAL_D;
        end else begin
          dn_n      = 1'b1;
          balance_n = balance - VAL_N;
        end
        if (balance_n == '0) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n == CHANGE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      balance     <= '0;
      bev_out     <= '0;
      disp_q      <= 1'b0;
      disp_d      <= 1'b0;
      disp_n      <= 1'b0;
      coin_reject <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      balance     <= balance_n;
      bev_out     <= bev_out_n;
      disp_q      <= dq_n;
      disp_d      <= dd_n;
      disp_n      <= dn_n;
      coin_reject <= rej_n;
      busy        <= busy_n;
    end
  end

`ifdef VEND_STOCK_EN
  localparam int STOCK_W = (STOCK_INIT < 2) ? 1 : $clog2(STOCK_INIT + 1);

  logic [STOCK_W-1:0] stock [NUM_BEV];

  // bev_out_n is non-zero only on a successful vend, so it doubles as the decrement strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BEV; i++) stock[i] <= STOCK_W'(STOCK_INIT);
    end else begin
      for (int i = 0; i < NUM_BEV; i++) begin
        if (bev_out_n[i]) stock[i] <= stock[i] - STOCK_W'(1);
      end
    end
  end

  always_comb begin
    sold_out = '0;
    for (int i = 0; i < NUM_BEV; i++) sold_out[i] = (stock[i] == '0);
  end
`else
  assign sold_out = '0;
`endif

endmodule
